// File: rtl/contador_modos.sv
// contador_modos -- mode-selectable up / down / down-by-step / load counter.
//
// Ports
//   clk     in   1      clock; all state changes on posedge
//   reset   in   1      synchronous, active-high; clears Q and rco
//   enable  in   1      1 = execute modo this edge, 0 = hold Q (rco drops)
//   modo    in   2      00 up, 01 down, 10 down by STEP_DOWN, 11 load D
//   D       in   WIDTH  parallel load value (modo 11 only)
//   Q       out  WIDTH  registered count
//   rco     out  1      registered carry/borrow pulse, coincident with wrapped Q
//
// Parameters
//   WIDTH      counter width; MAX = 2**WIDTH-1
//   STEP_DOWN  decrement for modo 10, legal range 1..MAX
//
// Build option
//   CONTADOR_SAT_EN  when defined, count operations saturate (up pins at MAX,
//                    down paths clamp at 0) and rco flags every clamped edge.
//                    Undefined: plain modular wrap.
module contador_modos #(
  parameter int WIDTH     = 4,
  parameter int STEP_DOWN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco
);

  typedef enum logic [1:0] {
    OP_UP      = 2'b00,
    OP_DN      = 2'b01,
    OP_DN_STEP = 2'b10,
    OP_LOAD    = 2'b11
  } op_e;

  localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(STEP_DOWN);
  localparam logic [WIDTH-1:0] MAX  = '1;

  // One extra MSB holds the carry (add) or borrow (subtract); it is exactly
  // the bit dropped by modular wrap, so it drives rco directly.
  logic [WIDTH:0]   wide;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;

  assign wide = {1'b0, Q};

  always_comb begin
    ext     = '0;
    q_nxt   = Q;
    rco_nxt = 1'b0;
    if (enable) begin
      case (op_e'(modo))
        OP_UP: begin
          ext     = wide + ONE;
          q_nxt   = ext[WIDTH-1:0];
          rco_nxt = ext[WIDTH];
`ifdef CONTADOR_SAT_EN
          if (ext[WIDTH]) q_nxt = MAX;
`endif
        end
        OP_DN: begin
          ext     = wide - ONE;
          q_nxt   = ext[WIDTH-1:0];
          rco_nxt = ext[WIDTH];
`ifdef CONTADOR_SAT_EN
          if (ext[WIDTH]) q_nxt = '0;
`endif
        end
        OP_DN_STEP: begin
          ext     = wide - STEP;
          q_nxt   = ext[WIDTH-1:0];
          rco_nxt = ext[WIDTH];
`ifdef CONTADOR_SAT_EN
          if (ext[WIDTH]) q_nxt = '0;
`endif
        end
        OP_LOAD: begin
          q_nxt   = D;
          rco_nxt = 1'b0;
        end
        // Unknown modo: treat as hold so X never propagates into Q.
        default: begin
          q_nxt   = Q;
          rco_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q   <= '0;
      rco <= 1'b0;
    end else begin
      Q   <= q_nxt;
      rco <= rco_nxt;
    end
  end

endmodule

// File: tb/tb_contador_modos.sv
// Bench for contador_modos (WIDTH=4, STEP_DOWN=3): directed vector table,
// then randomized traffic against an integer reference model.
module tb_contador_modos;

  localparam int WIDTH     = 4;
  localparam int STEP_DOWN = 3;
  localparam int MOD       = 1 << WIDTH;
  localparam int MAXV      = MOD - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       modo = 2'b00;
  logic [WIDTH-1:0] D = '0;
  logic [WIDTH-1:0] Q;
  logic             rco;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int mq = 0;
  int mr = 0;

  contador_modos #(.WIDTH(WIDTH), .STEP_DOWN(STEP_DOWN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .modo(modo), .D(D), .Q(Q), .rco(rco)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [WIDTH-1:0] d,
                              logic [WIDTH-1:0] q, logic c);
    vec_t v;
    v.rst = r; v.en = e; v.modo = m; v.d = d; v.q = q; v.rco = c;
    return v;
  endfunction

  // Integer model of one edge, from the operation rules (not the RTL).
  task automatic model_step(input logic r, input logic e, input logic [1:0] m,
                            input logic [WIDTH-1:0] d);
    int res;
    if (r) begin
      mq = 0; mr = 0;
    end else if (!e) begin
      mr = 0;
    end else if (m == 2'b11) begin
      mq = int'(d); mr = 0;
    end else begin
      case (m)
        2'b00:   res = mq + 1;
        2'b01:   res = mq - 1;
        default: res = mq - STEP_DOWN;
      endcase
      mr = (res > MAXV || res < 0) ? 1 : 0;
`ifdef CONTADOR_SAT_EN
      if (res > MAXV) mq = MAXV;
      else if (res < 0) mq = 0;
      else mq = res;
`else
      mq = (res + MOD) % MOD;
`endif
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [WIDTH-1:0] d);
    reset = r; enable = e; modo = m; D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] wq, input logic wr);
    n_cmp++;
    if (Q !== wq || rco !== wr) begin
      n_bad++;
      $display("FAIL %s: got Q=%h rco=%b, want Q=%h rco=%b", name, Q, rco, wq, wr);
    end
  endtask

  initial begin
`ifndef CONTADOR_SAT_EN
    // reset with enable/up asserted
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
    // load D, count up across MAX
    tbl.push_back(mk(0, 1, 2'b11, 4'hD, 4'hD, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'hE, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'hF, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h0, 1));
    // down through zero
    tbl.push_back(mk(0, 1, 2'b11, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 1, 2'b01, 4'h0, 4'hE, 0));
    // down by step through zero
    tbl.push_back(mk(0, 1, 2'b11, 4'h2, 4'h2, 0));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'hC, 0));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'h9, 0));
    // step-down from 1 gives 14 then 11
    tbl.push_back(mk(0, 1, 2'b11, 4'h1, 4'h1, 0));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'hE, 1));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'hB, 0));
    // hold while modo/D toggle, then reset overrides count
    tbl.push_back(mk(0, 1, 2'b11, 4'h7, 4'h7, 0));
    tbl.push_back(mk(0, 0, 2'b00, 4'hA, 4'h7, 0));
    tbl.push_back(mk(0, 0, 2'b11, 4'h5, 4'h7, 0));
    tbl.push_back(mk(0, 0, 2'b01, 4'hF, 4'h7, 0));
    tbl.push_back(mk(0, 0, 2'b10, 4'h0, 4'h7, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h1, 0));
    // rco drops when enable falls right after a wrap
    tbl.push_back(mk(0, 1, 2'b01, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 0, 2'b01, 4'h0, 4'hF, 0));
`else
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 4'hF, 4'hF, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 0, 2'b00, 4'h0, 4'hF, 0));
    tbl.push_back(mk(0, 1, 2'b11, 4'h1, 4'h1, 0));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 2'b11, 4'h3, 4'h3, 0));
    tbl.push_back(mk(0, 1, 2'b10, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 4'h0, 4'h1, 0));
    tbl.push_back(mk(1, 1, 2'b00, 4'h0, 4'h0, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].modo, tbl[i].d);
      check($sformatf("tbl[%0d]", i), tbl[i].q, tbl[i].rco);
    end

    // random traffic against the model, starting from a known reset
    drive(1, 0, 2'b00, '0);
    model_step(1, 0, 2'b00, '0);
    check("rnd_reset", WIDTH'(mq), mr[0]);
    for (int i = 0; i < 3000; i++) begin
      logic             r, e;
      logic [1:0]       m;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      d = WIDTH'($urandom);
      drive(r, e, m, d);
      model_step(r, e, m, d);
      check($sformatf("rnd[%0d]", i), WIDTH'(mq), mr[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
